logic_op_arbiter: RTL and testbench
===================================

# logic_op_arbiter

Shares one 16-bit logic unit between two requesters. Each requester submits an operand pair and an opcode over a valid/ready handshake. A round-robin arbiter grants one request at a time, the datapath computes the result in a single registered stage, and the result is returned on one response port tagged with the requester ID. The block sits between the control front-end and the shared logic datapath, so the logic unit needs no duplication.

## Interface
- WIDTH, 16: operand/result width; must be even (SPLIT op uses halves).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_op  in  2  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  WIDTH  result.
- rsp_id  out  1  ID of the requester that issued the result.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Opcodes:
  - 00 AND: a&b.
  - 01 OR: a|b.
  - 10 XOR: a^b.
  - 11 SPLIT: upper half a|b, lower half a&b.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - No valid: stay in IDLE.
  - Exactly one valid: grant it.
  - Both valid: grant requester `prio`.
  - On grant: assert that reqN_ready combinationally in the same cycle, capture a/b/op/id into registers, move to EXEC, set `prio` to the other requester.
- EXEC: the datapath computes from the captured operands. rsp_data and rsp_id load at the end of the cycle. Move to RESP.
- RESP: rsp_valid=1. On rsp_ready=1, move to IDLE. Otherwise hold.
- reqN_ready is 0 outside IDLE; it is never asserted for both requesters in the same cycle.
- A requester may drop valid before it is granted. No handshake occurs and the block has no memory of the request.
- Reset values:
  - state=IDLE, prio=0.
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - req0_ready=0, req1_ready=0 while rst=1.
- Reset mid-operation (EXEC or RESP) discards the pending result; no response is produced.

## Timing
- Request handshake at edge N (IDLE, valid&ready). State is EXEC in cycle N+1. rsp_valid=1 from cycle N+2.
- Minimum 3 cycles per transaction: grant, exec, response. The next grant comes no earlier than the cycle after the rsp handshake.
- rsp_data and rsp_id are stable while rsp_valid=1 && rsp_ready=0.
- rsp_ready held high: the response completes in one cycle (rsp_valid high for exactly one cycle).
- Operands on req ports are sampled only at the grant edge; later changes do not affect the result.
- Simultaneous valid on both after reset: requester 0 first, then requester 1 (prio alternates).
- busy rises the cycle after grant and falls the cycle after the rsp handshake.

## Structure
- Shared include `logic_defs.vh`: opcode constants OP_AND/OP_OR/OP_XOR/OP_SPLIT (2-bit), FSM state encodings S_IDLE/S_EXEC/S_RESP.
- Sub-module `logic_unit` (WIDTH param): purely combinational a, b, op -> res. Instantiated once and fed from the captured-operand registers.
- Top-level holds the FSM, prio flop, operand/op/id capture registers and the response registers.

## Test plan
- Single AND on req0: a=16'hF0F0, b=16'h0FF0, op=00 -> rsp_data=16'h00F0, rsp_id=0, rsp_valid at grant+2.
- SPLIT on req1: a=16'h12F0, b=16'h340F, op=11 -> rsp_data=16'h3600, rsp_id=1.
- Both valid continuously, req0 OR 16'h1200|16'h0034, req1 XOR 16'hFFFF^16'h00FF -> responses in order id0=16'h1234, id1=16'hFF00, id0, id1 … (strict alternation); ready never high for both requesters in one cycle.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id held; both reqN_ready=0; completes on the first rsp_ready=1.
- Operand change after grant: req0 a changes the cycle after handshake -> result reflects the captured value.
- rst=1 during EXEC with a pending request -> next cycle all outputs are at reset values, no response appears; after rst falls, a new req0 AND completes normally with rsp_id=0.

Source files
------------

// File: rtl/logic_op_arbiter_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter:
// opcode and FSM state encodings plus a half-width helper.
package logic_op_arbiter_pkg;

    // Opcode field width on each request port
    localparam int OP_W = 2;

    // Operations supported by the shared logic unit
    typedef enum logic [OP_W-1:0] {
        OP_AND   = 2'b00,
        OP_OR    = 2'b01,
        OP_XOR   = 2'b10,
        OP_SPLIT = 2'b11
    } op_e;

    // Arbiter/transaction states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

    // Width of one half of an operand; the SPLIT op treats the halves separately
    function automatic int half_width(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/logic_op_arbiter_logic_unit.sv
// Purely combinational 16-bit (parameterised) logic unit shared by both
// requesters. SPLIT returns OR on the upper half and AND on the lower half.
module logic_unit
    import logic_op_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    output logic [WIDTH-1:0] res_o
);

    localparam int HALF = half_width(WIDTH);

    // Select the result for the requested operation
    always_comb begin
        res_o = '0;
        case (op_e'(op_i))
            OP_AND:   res_o = a_i & b_i;
            OP_OR:    res_o = a_i | b_i;
            OP_XOR:   res_o = a_i ^ b_i;
            OP_SPLIT: res_o = {a_i[WIDTH-1:HALF] | b_i[WIDTH-1:HALF],
                               a_i[HALF-1:0]     & b_i[HALF-1:0]};
            default:  res_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic unit between two requesters.
// Each transaction takes grant -> exec -> response, and the result is
// returned tagged with the ID of the requester that issued it.
module logic_op_arbiter
    import logic_op_arbiter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,

    output logic             busy
);

    // Control state
    state_e           state_q;
    logic             prio_q;
    logic             rsp_valid_q;
    logic             busy_q;

    // Response registers
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_id_q;

    // Captured request (operands are sampled only at the grant edge)
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             id_q, id_d;

    // Arbitration results for this cycle
    logic             grant0;
    logic             grant1;
    logic             grant_any;
    logic [WIDTH-1:0] lu_res;

    // Round-robin grant: a lone requester wins outright, a tie goes to prio_q.
    // Gated by rst so neither ready is ever seen while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state_q == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = (prio_q == 1'b0);
                grant1 = (prio_q == 1'b1);
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign grant_any = grant0 | grant1;

    // Mux the winning requester's fields toward the capture registers
    always_comb begin
        a_d  = grant1 ? req1_a  : req0_a;
        b_d  = grant1 ? req1_b  : req0_b;
        op_d = grant1 ? req1_op : req0_op;
        id_d = grant1;
    end

    // Capture the granted request; pure data, so no reset is needed
    always_ff @(posedge clk) begin
        if (grant_any) begin
            a_q  <= a_d;
            b_q  <= b_d;
            op_q <= op_d;
            id_q <= id_d;
        end
    end

    // Single shared logic unit fed from the captured operands
    logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic_unit (
        .a_i   (a_q),
        .b_i   (b_q),
        .op_i  (op_q),
        .res_o (lu_res)
    );

    // Transaction FSM with registered response, busy and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        state_q <= S_EXEC;
                        busy_q  <= 1'b1;
                        // Hand priority to the requester that just lost out
                        prio_q  <= grant0;
                    end
                end
                S_EXEC: begin
                    rsp_data_q  <= lu_res;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: directed scenarios followed by randomized
// traffic checked against a transaction-level reference model.
module tb_logic_op_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_op, req1_op;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_data;
    logic         busy;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic         id;
        logic [W-1:0] d;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    logic_op_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    // Reference result straight from the opcode table
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
        logic [W-1:0] r;
        case (op)
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: begin
                r[W-1:W/2] = a[W-1:W/2] | b[W-1:W/2];
                r[W/2-1:0] = a[W/2-1:0] & b[W/2-1:0];
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
    endtask

    // Wait (bounded) until the block is idle, consuming any response
    task automatic drain();
        int n = 0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        while ((busy || rsp_valid) && n < 20) begin step(); n++; end
        chk("drain_idle", {31'd0, n < 20}, 32'd1);
    endtask

    // One complete transaction with rsp_ready high; a_late overwrites the
    // requester's a operand the cycle after the handshake.
    task automatic txn(input string tag, input bit id, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [1:0] op,
                       input logic [W-1:0] a_late, input logic [W-1:0] exp);
        int n = 0;
        rsp_ready = 1;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin step(); n++; end
        chk({tag, "_granted"}, {31'd0, n < 20}, 32'd1);
        chk({tag, "_other_ready"}, {31'd0, id ? req0_ready : req1_ready}, 32'd0);
        step();
        req0_valid = 0; req1_valid = 0;
        if (id) req1_a = a_late; else req0_a = a_late;
        chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_exec_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        step();
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_rsp_data"}, {16'd0, rsp_data}, {16'd0, exp});
        chk({tag, "_rsp_id"}, {31'd0, rsp_id}, {31'd0, id});
        step();
        chk({tag, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int got;
        bit exp_id;
        bit outstanding;
        int age;
        bit mprio;
        bit e0, e1, hs;
        exp_t e;

        // ---------------- reset ----------------
        idle_inputs();
        rsp_ready = 0;
        rst = 1;
        repeat (3) step();
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        req0_valid = 1; req1_valid = 1; #1;
        chk("rst_held_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_held_ready1", {31'd0, req1_ready}, 32'd0);
        idle_inputs();
        rst = 0;
        step();

        // ---------------- single AND on req0, SPLIT on req1 ----------------
        txn("and0", 1'b0, 16'hF0F0, 16'h0FF0, 2'b00, 16'hF0F0, 16'h00F0);
        txn("split1", 1'b1, 16'h12F0, 16'h340F, 2'b11, 16'h12F0, 16'h3600);

        // ---------------- both valid: strict alternation ----------------
        req0_valid = 1; req0_a = 16'h1200; req0_b = 16'h0034; req0_op = 2'b01;
        req1_valid = 1; req1_a = 16'hFFFF; req1_b = 16'h00FF; req1_op = 2'b10;
        rsp_ready = 1;
        got = 0; n = 0; exp_id = 0;
        #1;
        while (got < 4 && n < 40) begin
            chk("alt_not_both_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (rsp_valid) begin
                chk($sformatf("alt_id_%0d", got), {31'd0, rsp_id}, {31'd0, exp_id});
                chk($sformatf("alt_data_%0d", got), {16'd0, rsp_data},
                    {16'd0, exp_id ? 16'hFF00 : 16'h1234});
                exp_id = ~exp_id;
                got++;
            end
            step();
            n++;
        end
        chk("alt_count", got, 4);
        drain();

        // ---------------- backpressure ----------------
        req0_valid = 1; req0_a = 16'hAAAA; req0_b = 16'h5555; req0_op = 2'b10;
        rsp_ready = 0;
        n = 0; #1;
        while (!req0_ready && n < 20) begin step(); n++; end
        chk("bp_granted", {31'd0, n < 20}, 32'd1);
        step();
        req0_valid = 0; req1_valid = 1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp_data_%0d", i), {16'd0, rsp_data}, 32'h0000FFFF);
            chk($sformatf("bp_id_%0d", i), {31'd0, rsp_id}, 32'd0);
            chk($sformatf("bp_ready_%0d", i), {30'd0, req0_ready, req1_ready}, 32'd0);
            step();
        end
        rsp_ready = 1;
        step();
        chk("bp_released", {31'd0, rsp_valid}, 32'd0);
        drain();

        // ---------------- operand change after grant ----------------
        txn("late_a", 1'b0, 16'h0F0F, 16'h00FF, 2'b01, 16'hFFFF, 16'h0FFF);

        // ---------------- reset during EXEC ----------------
        req0_valid = 1; req0_a = 16'hFFFF; req0_b = 16'h1234; req0_op = 2'b00;
        rsp_ready = 1;
        n = 0; #1;
        while (!req0_ready && n < 20) begin step(); n++; end
        step();
        req0_valid = 0; req1_valid = 1;
        req1_a = 16'h1111; req1_b = 16'h2222; req1_op = 2'b01;
        rst = 1;
        step();
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_data", {16'd0, rsp_data}, 32'd0);
        chk("mid_rst_id", {31'd0, rsp_id}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        req1_valid = 0;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("mid_rst_no_rsp_%0d", i), {31'd0, rsp_valid}, 32'd0);
        end
        txn("post_rst_and", 1'b0, 16'h3C3C, 16'h0FF0, 2'b00, 16'h3C3C, 16'h0C30);

        // ---------------- randomized traffic vs. reference model ----------------
        rst = 1; idle_inputs(); step(); rst = 0;
        outstanding = 0; age = 0; mprio = 0;
        for (int c = 0; c < 400; c++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_a = W'($urandom); req0_b = W'($urandom); req0_op = 2'($urandom);
            req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 2'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            e0 = !outstanding && req0_valid && (!req1_valid || mprio == 0);
            e1 = !outstanding && req1_valid && (!req0_valid || mprio == 1);
            chk("rnd_ready0", {31'd0, req0_ready}, {31'd0, e0});
            chk("rnd_ready1", {31'd0, req1_ready}, {31'd0, e1});
            chk("rnd_busy", {31'd0, busy}, {31'd0, outstanding});
            chk("rnd_rsp_valid", {31'd0, rsp_valid}, {31'd0, outstanding && age >= 1});
            if (outstanding && age >= 1 && exp_q.size() > 0) begin
                chk("rnd_rsp_data", {16'd0, rsp_data}, {16'd0, exp_q[0].d});
                chk("rnd_rsp_id", {31'd0, rsp_id}, {31'd0, exp_q[0].id});
            end
            hs = outstanding && age >= 1 && rsp_ready;
            if (e0 || e1) begin
                e.id = e1;
                e.d  = e1 ? ref_op(req1_a, req1_b, req1_op) : ref_op(req0_a, req0_b, req0_op);
                exp_q.push_back(e);
                outstanding = 1;
                age = 0;
                mprio = e0;
            end else if (hs) begin
                void'(exp_q.pop_front());
                outstanding = 0;
            end else if (outstanding) begin
                age++;
            end
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
